// File: rtl/npu_pkg.sv
// Shared command, select, opcode and state definitions for the NPU command sequencer.
package npu_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_START = 8'h02;

    localparam logic [1:0] SEL_A     = 2'b00;
    localparam logic [1:0] SEL_B     = 2'b01;
    localparam logic [1:0] SEL_RST   = 2'b10;
    localparam logic [1:0] SEL_CADDR = 2'b11;

    typedef enum logic [2:0] {
        OP_ADD = 3'd1,
        OP_SUB = 3'd2,
        OP_MUL = 3'd3,
        OP_MAX = 3'd4
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        FINISH
    } state_e;

    // The ALU understands codes OP_ADD..OP_MAX; anything else is rejected at START.
    function automatic logic opc_valid(input logic [2:0] opc);
        return (opc >= 3'(OP_ADD)) && (opc <= 3'(OP_MAX));
    endfunction

endpackage

// File: rtl/npu_seq_ctrl.sv
// Command sequencer: turns decoded SPI frames into SRAM_A/B loads and steps the
// element ALU over one tile (read A[i]/B[i], wait one cycle, write C[i]).
module npu_seq_ctrl
    import npu_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 8,
    parameter int TILE_ELEMS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frm_valid,
    input  logic [7:0]        frm_cmd,
    input  logic [1:0]        frm_sel,
    input  logic [2:0]        frm_opc,
    input  logic [DATA_W-1:0] frm_din,
    output logic              wr_a_en,
    output logic              wr_b_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [2:0]        alu_opc,
    input  logic [DATA_W-1:0] alu_result,
    output logic              c_we,
    output logic [ADDR_W-1:0] c_waddr,
    output logic [DATA_W-1:0] c_wdata,
    output logic [ADDR_W-1:0] c_raddr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] LAST_ELEM = ADDR_W'(TILE_ELEMS - 1);

    state_e            state, state_next;
    logic [ADDR_W-1:0] elem, elem_next;
    logic [ADDR_W-1:0] a_ptr, a_ptr_next;
    logic [ADDR_W-1:0] b_ptr, b_ptr_next;

    logic              wr_a_en_next, wr_b_en_next;
    logic [ADDR_W-1:0] wr_addr_next;
    logic [DATA_W-1:0] wr_data_next;
    logic              rd_en_next;
    logic [ADDR_W-1:0] rd_addr_next;
    logic [2:0]        alu_opc_next;
    logic              c_we_next;
    logic [ADDR_W-1:0] c_waddr_next;
    logic [DATA_W-1:0] c_wdata_next;
    logic [ADDR_W-1:0] c_raddr_next;
    logic              busy_next, done_next, err_next;

    logic              busy_now;

    // FINISH still counts as busy, so a frame landing on that cycle is rejected.
    assign busy_now = (state != IDLE);

    always_comb begin
        // NOTE: every *_next signal gets a default first, so no path through this block can infer a latch.
        state_next   = state;
        elem_next    = elem;
        a_ptr_next   = a_ptr;
        b_ptr_next   = b_ptr;
        wr_a_en_next = 1'b0;
        wr_b_en_next = 1'b0;
        wr_addr_next = wr_addr;
        wr_data_next = wr_data;
        rd_en_next   = 1'b0;
        rd_addr_next = rd_addr;
        alu_opc_next = alu_opc;
        c_we_next    = 1'b0;
        c_waddr_next = c_waddr;
        c_wdata_next = c_wdata;
        c_raddr_next = c_raddr;
        done_next    = done;
        err_next     = 1'b0;

        if (frm_valid) begin
            unique case (frm_cmd)
                CMD_WRITE: begin
                    if (frm_sel == SEL_CADDR) begin
                        c_raddr_next = ADDR_W'(frm_din);
                        done_next    = 1'b0;
                    end else if (busy_now) begin
                        err_next = 1'b1;
                    end else begin
                        done_next = 1'b0;
                        unique case (frm_sel)
                            SEL_A: begin
                                wr_a_en_next = 1'b1;
                                wr_addr_next = a_ptr;
                                wr_data_next = frm_din;
                                a_ptr_next   = a_ptr + ADDR_W'(1);
                            end
                            SEL_B: begin
                                wr_b_en_next = 1'b1;
                                wr_addr_next = b_ptr;
                                wr_data_next = frm_din;
                                b_ptr_next   = b_ptr + ADDR_W'(1);
                            end
                            default: begin
                                a_ptr_next = '0;
                                b_ptr_next = '0;
                            end
                        endcase
                    end
                end
                CMD_START: begin
                    if (!busy_now && opc_valid(frm_opc)) begin
                        alu_opc_next = frm_opc;
                        elem_next    = '0;
                        done_next    = 1'b0;
                        state_next   = READ;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: err_next = 1'b1;
            endcase
        end

        unique case (state)
            IDLE: ;
            READ: begin
                rd_en_next   = 1'b1;
                rd_addr_next = elem;
                state_next   = WAIT;
            end
            WAIT: state_next = WRITE;
            WRITE: begin
                // alu_result reflects A[elem]/B[elem] registered by the SRAMs one cycle earlier.
                c_we_next    = 1'b1;
                c_waddr_next = elem;
                c_wdata_next = alu_result;
                if (elem == LAST_ELEM) begin
                    state_next = FINISH;
                end else begin
                    elem_next  = elem + ADDR_W'(1);
                    state_next = READ;
                end
            end
            FINISH: begin
                done_next  = 1'b1;
                a_ptr_next = '0;
                b_ptr_next = '0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            elem    <= '0;
            a_ptr   <= '0;
            b_ptr   <= '0;
            wr_a_en <= 1'b0;
            wr_b_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            alu_opc <= '0;
            c_we    <= 1'b0;
            c_waddr <= '0;
            c_wdata <= '0;
            c_raddr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values computed above.
            state   <= state_next;
            elem    <= elem_next;
            a_ptr   <= a_ptr_next;
            b_ptr   <= b_ptr_next;
            wr_a_en <= wr_a_en_next;
            wr_b_en <= wr_b_en_next;
            wr_addr <= wr_addr_next;
            wr_data <= wr_data_next;
            rd_en   <= rd_en_next;
            rd_addr <= rd_addr_next;
            alu_opc <= alu_opc_next;
            c_we    <= c_we_next;
            c_waddr <= c_waddr_next;
            c_wdata <= c_wdata_next;
            c_raddr <= c_raddr_next;
            busy    <= busy_next;
            done    <= done_next;
            err     <= err_next;
        end
    end

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// Randomized self-checking bench for npu_seq_ctrl with SRAM/ALU environment
// models and an array-based reference of the loaded tile contents.
module tb_npu_seq_ctrl;
    import npu_pkg::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;
    localparam int TILE   = 16;

    logic              clk;
    logic              rst_n;
    logic              frm_valid;
    logic [7:0]        frm_cmd;
    logic [1:0]        frm_sel;
    logic [2:0]        frm_opc;
    logic [DATA_W-1:0] frm_din;
    logic              wr_a_en, wr_b_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        alu_opc;
    logic [DATA_W-1:0] alu_result;
    logic              c_we;
    logic [ADDR_W-1:0] c_waddr;
    logic [DATA_W-1:0] c_wdata;
    logic [ADDR_W-1:0] c_raddr;
    logic              busy, done, err;

    npu_seq_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TILE_ELEMS(TILE)) dut (
        .clk(clk), .rst_n(rst_n),
        .frm_valid(frm_valid), .frm_cmd(frm_cmd), .frm_sel(frm_sel),
        .frm_opc(frm_opc), .frm_din(frm_din),
        .wr_a_en(wr_a_en), .wr_b_en(wr_b_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .alu_opc(alu_opc), .alu_result(alu_result),
        .c_we(c_we), .c_waddr(c_waddr), .c_wdata(c_wdata), .c_raddr(c_raddr),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Element ALU behaviour: ADD, SUB, MUL low byte, MAX.
    function automatic logic [7:0] alu_fn(input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'(a) * 16'(b);
        case (opc)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return p[7:0];
            3'd4:    return (a > b) ? a : b;
            default: return 8'h00;
        endcase
    endfunction

    // SRAM_A/B environment with one-cycle registered read.
    logic [7:0] sram_a [1024];
    logic [7:0] sram_b [1024];
    logic [7:0] rd_a, rd_b;
    always @(posedge clk) begin
        if (wr_a_en) sram_a[wr_addr] <= wr_data;
        if (wr_b_en) sram_b[wr_addr] <= wr_data;
        if (rd_en) begin
            rd_a <= sram_a[rd_addr];
            rd_b <= sram_b[rd_addr];
        end
    end
    assign alu_result = alu_fn(alu_opc, rd_a, rd_b);

    // Reference model: what has been loaded where, and where the pointers stand.
    logic [7:0]  ref_a [1024];
    logic [7:0]  ref_b [1024];
    logic [9:0]  m_aptr, m_bptr, m_craddr;

    typedef struct packed {
        logic [9:0] addr;
        logic [7:0] data;
    } cwr_t;
    cwr_t c_q[$];
    int   rd_cnt = 0, wr_cnt = 0, err_cnt = 0, overlap_cnt = 0;

    always @(negedge clk) begin
        if (c_we) c_q.push_back({c_waddr, c_wdata});
        if (rd_en) rd_cnt++;
        if (wr_a_en || wr_b_en) wr_cnt++;
        if (err) err_cnt++;
        if ((wr_a_en || wr_b_en) && (rd_en || c_we)) overlap_cnt++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_wr"}, {wr_a_en, wr_b_en, wr_addr, wr_data}, 32'd0);
        check({tag, "_rd"}, {rd_en, rd_addr, alu_opc}, 32'd0);
        check({tag, "_c"}, {c_we, c_waddr, c_wdata, c_raddr}, 32'd0);
        check({tag, "_st"}, {busy, done, err}, 32'd0);
    endtask

    task automatic put_frame(input logic [7:0] cmd, input logic [1:0] sel,
                             input logic [2:0] opc, input logic [7:0] din);
        frm_cmd   = cmd;
        frm_sel   = sel;
        frm_opc   = opc;
        frm_din   = din;
        frm_valid = 1'b1;
    endtask

    // Returns on the falling edge right after the frame was sampled.
    task automatic send_frame(input logic [7:0] cmd, input logic [1:0] sel,
                              input logic [2:0] opc, input logic [7:0] din);
        @(negedge clk);
        put_frame(cmd, sel, opc, din);
        @(negedge clk);
        frm_valid = 1'b0;
    endtask

    task automatic load(input logic [1:0] sel, input logic [7:0] din);
        send_frame(CMD_WRITE, sel, 3'd0, din);
        case (sel)
            SEL_A: begin
                check("wr_a", {wr_a_en, wr_b_en, wr_addr, wr_data}, {1'b1, 1'b0, m_aptr, din});
                ref_a[m_aptr] = din;
                m_aptr++;
            end
            SEL_B: begin
                check("wr_b", {wr_a_en, wr_b_en, wr_addr, wr_data}, {1'b0, 1'b1, m_bptr, din});
                ref_b[m_bptr] = din;
                m_bptr++;
            end
            SEL_RST: begin
                check("ptr_rst", {wr_a_en, wr_b_en, err}, 32'd0);
                m_aptr = '0;
                m_bptr = '0;
            end
            default: begin
                m_craddr = {2'b00, din};
                check("c_raddr_set", c_raddr, m_craddr);
            end
        endcase
    endtask

    task automatic load_tile_random();
        load(SEL_RST, 8'h00);
        for (int i = 0; i < TILE; i++) load(SEL_A, 8'($urandom));
        for (int i = 0; i < TILE; i++) load(SEL_B, 8'($urandom));
    endtask

    // abort_at < 0 runs to completion; otherwise rst_n drops on that cycle count.
    task automatic run_op(input logic [2:0] opc, input bit inject, input int abort_at);
        int n;
        int c_base, err0, wr0, exp_cnt;
        bit aborted;
        @(posedge clk);
        c_base  = c_q.size();
        err0    = err_cnt;
        wr0     = wr_cnt;
        aborted = 1'b0;
        send_frame(CMD_START, 2'b00, opc, 8'h00);
        check("start_state", {busy, done, err, alu_opc}, {1'b1, 1'b0, 1'b0, opc});
        n = 1;
        while (!done && n < 200) begin
            frm_valid = 1'b0;
            if (n == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_zero("abort");
                m_aptr   = '0;
                m_bptr   = '0;
                m_craddr = '0;
                repeat (3) @(negedge clk);
                aborted = 1'b1;
                break;
            end
            if (inject) begin
                case (n)
                    5:  put_frame(CMD_WRITE, SEL_A, 3'd0, 8'hAA);
                    10: put_frame(CMD_START, 2'b00, 3'd2, 8'h00);
                    15: put_frame(CMD_WRITE, SEL_CADDR, 3'd0, 8'h05);
                    49: put_frame(CMD_WRITE, SEL_A, 3'd0, 8'h55);
                    default: ;
                endcase
            end
            @(negedge clk);
            n++;
        end
        frm_valid = 1'b0;
        if (aborted) begin
            exp_cnt = (abort_at - 1) / 3;
            @(negedge clk);
            rst_n = 1'b1;
            @(posedge clk);
        end else begin
            exp_cnt = TILE;
            check("latency", n, 50);
            check("end_state", {busy, done}, 2'b01);
            m_aptr = '0;
            m_bptr = '0;
            if (inject) m_craddr = 10'd5;
            @(posedge clk);
            check("wr_during_op", wr_cnt - wr0, 0);
            check("err_during_op", err_cnt - err0, inject ? 3 : 0);
            check("c_raddr", c_raddr, m_craddr);
        end
        check("c_count", c_q.size() - c_base, exp_cnt);
        for (int i = c_base; i < c_q.size(); i++) begin
            int idx;
            idx = i - c_base;
            check("c_wr", c_q[i], {10'(idx), alu_fn(opc, ref_a[idx], ref_b[idx])});
        end
    endtask

    initial begin
        int rd0;
        rst_n     = 1'b0;
        frm_valid = 1'b0;
        frm_cmd   = '0;
        frm_sel   = '0;
        frm_opc   = '0;
        frm_din   = '0;
        m_aptr    = '0;
        m_bptr    = '0;
        m_craddr  = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Directed load of ones and twos, then ADD.
        for (int i = 0; i < TILE; i++) load(SEL_A, 8'h01);
        for (int i = 0; i < TILE; i++) load(SEL_B, 8'h02);
        run_op(3'd1, 1'b0, -1);
        repeat (3) @(negedge clk);
        check("done_hold", done, 1'b1);
        load(SEL_A, 8'h11);
        check("done_clr_wr", done, 1'b0);
        load(SEL_B, 8'h22);

        // Frames arriving while busy, including on the FINISH cycle.
        load_tile_random();
        run_op(3'($urandom_range(1, 4)), 1'b1, -1);

        // Rejected STARTs and an unknown command from IDLE.
        @(posedge clk);
        rd0 = rd_cnt;
        send_frame(CMD_START, 2'b00, 3'd0, 8'h00);
        check("bad_opc0", {err, busy}, 2'b10);
        send_frame(CMD_START, 2'b00, 3'd7, 8'h00);
        check("bad_opc7", {err, busy}, 2'b10);
        send_frame(8'h7F, 2'b00, 3'd1, 8'h00);
        check("bad_cmd", {err, busy}, 2'b10);
        repeat (3) @(negedge clk);
        @(posedge clk);
        check("bad_no_rd", rd_cnt - rd0, 0);

        // Random tiles with random opcodes.
        for (int k = 0; k < 3; k++) begin
            load_tile_random();
            run_op(3'($urandom_range(1, 4)), 1'b0, -1);
        end

        // Reset during WAIT of element 7, then a clean operation.
        load_tile_random();
        run_op(3'($urandom_range(1, 4)), 1'b0, 23);
        check_zero("post_abort");
        for (int i = 0; i < TILE; i++) load(SEL_A, 8'($urandom));
        for (int i = 0; i < TILE; i++) load(SEL_B, 8'($urandom));
        run_op(3'($urandom_range(1, 4)), 1'b0, -1);

        load(SEL_CADDR, 8'hC3);

        // Pointer wrap past 1023, then explicit pointer reset.
        load(SEL_RST, 8'h00);
        for (int i = 0; i < 1030; i++) load(SEL_A, 8'($urandom));
        load(SEL_RST, 8'h00);
        load(SEL_A, 8'h5A);

        check("no_overlap", overlap_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/npu_seq_ctrl.md
Name: npu_seq_ctrl

Overview:
- Command sequencer between the SPI frame decoder and the NPU datapath (SRAM_A, SRAM_B, SRAM_C, element ALU).
- Consumes decoded 24-bit SPI frames and issues loads to SRAM_A and SRAM_B.
- Latches the readback address for SRAM_C.
- On START, steps the ALU over one tile: read A[i]/B[i], evaluate, write C[i]. Then raises `done`.

Parameters:
- ADDR_W, 10, SRAM address width.
- DATA_W, 8, element width.
- TILE_ELEMS, 16, elements per operation (4x4 tile); must be ≤ 2**ADDR_W.

Ports:
- clk  in  1  system clock (27 MHz).
- rst_n  in  1  asynchronous active-low reset.
- frm_valid  in  1  one-cycle strobe: decoded frame present.
- frm_cmd  in  8  frame command byte.
- frm_sel  in  2  {ti[0], tj[0]}: target select.
- frm_opc  in  3  operation code.
- frm_din  in  DATA_W  frame data byte.
- wr_a_en  out  1  SRAM_A write enable.
- wr_b_en  out  1  SRAM_B write enable.
- wr_addr  out  ADDR_W  A/B write address.
- wr_data  out  DATA_W  A/B write data.
- rd_en  out  1  A/B read enable (shared address).
- rd_addr  out  ADDR_W  A/B read address.
- alu_opc  out  3  opcode to ALU, held for the whole operation.
- alu_result  in  DATA_W  combinational ALU output from registered A/B read data.
- c_we  out  1  SRAM_C write enable.
- c_waddr  out  ADDR_W  SRAM_C write address.
- c_wdata  out  DATA_W  SRAM_C write data (= alu_result).
- c_raddr  out  ADDR_W  SRAM_C readback address toward the MISO path.
- busy  out  1  operation in progress.
- done  out  1  operation complete (level).
- err  out  1  one-cycle pulse on a rejected frame.

Behaviour:
- Reset: state IDLE; all outputs 0; a_ptr = b_ptr = 0; alu_opc = 0; c_raddr = 0. Reset mid-operation aborts immediately with no further SRAM writes.
- All outputs are registered. Frames are sampled only on cycles where frm_valid = 1.

WRITE frame (cmd 0x01), decoded by frm_sel:
- 00: wr_a_en = 1 next cycle, wr_addr = a_ptr, wr_data = frm_din; then a_ptr++.
- 01: same for SRAM_B, using b_ptr.
- 10: a_ptr = b_ptr = 0; no SRAM access.
- 11: c_raddr = zero-extended frm_din; accepted even while busy.
- Pointer wrap: modulo 2**ADDR_W.
- Any WRITE with sel 00/01/10 while busy: ignored, err pulse.
- Any accepted WRITE clears `done`.

START frame (cmd 0x02):
- Accepted only in IDLE with frm_opc in 1..4 (1 ADD, 2 SUB, 3 MUL low byte, 4 MAX). The ALU implements these; this block only forwards the code.
- On accept: latch alu_opc, i = 0, busy = 1, done = 0; go to READ.
- Bad opc, or START while busy: ignored, err pulse, state unchanged.
- Any other cmd value: err pulse.

FSM (3 cycles per element):
- IDLE: wait for START.
- READ: rd_en = 1, rd_addr = i → WAIT.
- WAIT: SRAM read latency (1 cycle) → WRITE.
- WRITE: c_we = 1, c_waddr = i, c_wdata = alu_result.
  - If i == TILE_ELEMS-1 → FINISH.
  - Otherwise i++ → READ.
- FINISH: busy = 0, done = 1, a_ptr = b_ptr = 0 → IDLE.

Timing and boundaries:
- Latency: START frame cycle to done = 1 is 3*TILE_ELEMS + 2 cycles (50 cycles for a 16-element tile).
- `done` holds until the next accepted START or WRITE.
- wr_a_en/wr_b_en never coincide with rd_en or c_we, because loads are rejected while busy.
- A frame arriving on the FINISH cycle is evaluated as busy.

Decomposition:
- Package npu_pkg holds:
  - command constants: CMD_WRITE = 8'h01, CMD_START = 8'h02;
  - opcode enum: OP_ADD, OP_SUB, OP_MUL, OP_MAX;
  - select constants: SEL_A, SEL_B, SEL_RST, SEL_CADDR;
  - state typedef: IDLE, READ, WAIT, WRITE, FINISH.
- Single module; no sub-module. Pointer and element counters stay inline.

Test Plan:
- 16 WRITE frames sel 00, din 0x01, then 16 sel 01, din 0x02 → wr_a_en/wr_b_en pulses at addresses 0..15 with data 01/02; a_ptr = b_ptr = 16.
- START opc 1, model ALU = A+B → c_we at addresses 0..15 with data 0x03; done rises exactly 50 cycles after the frame; busy low and pointers 0 afterward.
- WRITE sel 00 and START, both issued while busy → err pulses, no wr_a_en, operation completes unaffected; WRITE sel 11, din 0x05 while busy → c_raddr = 5.
- START with opc 0 and opc 7 from IDLE → err pulse, busy stays 0, no rd_en; cmd 0x7F → err pulse.
- Assert rst_n low during WAIT of element 7 → all outputs 0 asynchronously, no further c_we; a new load and START completes normally.
- 1030 WRITE frames sel 00 → wr_addr wraps 1023 → 0; WRITE sel 10 → next write at address 0.
